// File: rtl/dtfag_seq_ctrl_pkg.sv
// dtfag_seq_ctrl_pkg: shared FFT sequencer types and sizing defaults
package dtfag_seq_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;
  localparam int DEF_RADIX_WIDTH = 4;
  localparam int DEF_NUM_STAGE = 4;
  localparam int TUPLES_PER_STAGE = 1 << (3 * DEF_RADIX_WIDTH);
endpackage

// File: rtl/dtfag_seq_ctrl_idx_cnt.sv
// dtfag_idx_cnt: cascaded i/t/j index counter, j fastest, with stage terminal count
module dtfag_idx_cnt #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         clr,
  output logic [W-1:0] i_o,
  output logic [W-1:0] t_o,
  output logic [W-1:0] j_o,
  output logic         tc_o
);
  assign tc_o = &{i_o, t_o, j_o};
  // one wide increment gives the j->t->i carry chain for free
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) {i_o, t_o, j_o} <= '0;
    else if (clr) {i_o, t_o, j_o} <= '0;
    else if (en) {i_o, t_o, j_o} <= {i_o, t_o, j_o} + (3 * W)'(1);
endmodule

// File: rtl/dtfag_seq_ctrl.sv
// dtfag_seq_ctrl: DTFAG twiddle address sequencer with ROM enable and valid pipeline
// Optional stall input enabled by defining DTFAG_STALL_EN.
module dtfag_seq_ctrl
  import dtfag_seq_ctrl_pkg::*;
#(
  parameter int RADIX_WIDTH = DEF_RADIX_WIDTH,
  parameter int NUM_STAGE = DEF_NUM_STAGE,
  parameter int ROM_LAT = 1,
  localparam int SW = NUM_STAGE > 1 ? $clog2(NUM_STAGE) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
`ifdef DTFAG_STALL_EN
  input  logic                   stall,
`endif
  output logic                   busy,
  output logic                   done,
  output logic [SW-1:0]          stage,
  output logic [RADIX_WIDTH-1:0] DTFAG_i,
  output logic [RADIX_WIDTH-1:0] DTFAG_t,
  output logic [RADIX_WIDTH-1:0] DTFAG_j,
  output logic                   ROM_CEN,
  output logic                   tw_valid
);
  state_e state_q;
  logic busy_q, done_q, rom_cen_q;
  logic [SW-1:0] stage_q;
  logic [2:0] drain_q;
  logic [ROM_LAT-1:0] vld_q;
  logic [ROM_LAT:0] vld_sh;
  logic stall_w, issue, tc, last;
`ifdef DTFAG_STALL_EN
  assign stall_w = stall;
`else
  assign stall_w = 1'b0;
`endif
  // a tuple is issued in every RUN cycle whose registered enable is low
  assign issue = state_q == RUN && !rom_cen_q;
  assign last = issue && tc && stage_q == SW'(NUM_STAGE - 1);
  assign vld_sh = {vld_q, ~rom_cen_q};
  dtfag_idx_cnt #(.W(RADIX_WIDTH)) u_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (issue),
    .clr  (state_q == DONE),
    .i_o  (DTFAG_i),
    .t_o  (DTFAG_t),
    .j_o  (DTFAG_j),
    .tc_o (tc)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      rom_cen_q <= 1'b1;
      stage_q <= '0;
      drain_q <= '0;
      vld_q <= '0;
    end else begin
      vld_q <= vld_sh[ROM_LAT-1:0];
      case (state_q)
        IDLE:
          if (start) begin
            state_q <= RUN;
            busy_q <= 1'b1;
            rom_cen_q <= 1'b0;
          end
        RUN: begin
          if (issue && tc) stage_q <= last ? '0 : stage_q + SW'(1);
          if (last) begin
            state_q <= DRAIN;
            rom_cen_q <= 1'b1;
            drain_q <= '0;
          end else rom_cen_q <= stall_w;
        end
        DRAIN:
          if (drain_q == 3'(ROM_LAT - 1)) begin
            state_q <= DONE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end else drain_q <= drain_q + 3'd1;
        DONE: begin
          state_q <= IDLE;
          done_q <= 1'b0;
          stage_q <= '0;
        end
        default: state_q <= IDLE;
      endcase
    end
  assign busy = busy_q;
  assign done = done_q;
  assign stage = stage_q;
  assign ROM_CEN = rom_cen_q;
  assign tw_valid = vld_sh[ROM_LAT];
endmodule

// File: tb/tb_dtfag_seq_ctrl.sv
// tb_dtfag_seq_ctrl: randomized bench with an issue-count reference model
module tb_dtfag_seq_ctrl;
`ifdef DTFAG_STALL_EN
  localparam int LAT = 2;
  localparam int NST = 7;
`else
  localparam int LAT = 1;
  localparam int NST = 0;
`endif
  localparam int TOTAL = 16384;
  logic clk, rst_n, start, stall;
  logic busy, done, ROM_CEN, tw_valid;
  logic [1:0] stage;
  logic [3:0] DTFAG_i, DTFAG_t, DTFAG_j;
  int vectors = 0, errs = 0;
  dtfag_seq_ctrl #(.RADIX_WIDTH(4), .NUM_STAGE(4), .ROM_LAT(LAT)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
`ifdef DTFAG_STALL_EN
    .stall   (stall),
`endif
    .busy    (busy),
    .done    (done),
    .stage   (stage),
    .DTFAG_i (DTFAG_i),
    .DTFAG_t (DTFAG_t),
    .DTFAG_j (DTFAG_j),
    .ROM_CEN (ROM_CEN),
    .tw_valid(tw_valid)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errs++;
      if (errs <= 30) $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask
  // reference: mode plus the number of tuples issued so far; indices follow from that count
  initial begin
    int m_mode, m_k, m_d, kk;
    logic m_cen, st;
    logic [7:0] m_vh;
    logic [17:0] exp;
    m_mode = 0; m_k = 0; m_d = 0; m_cen = 1'b1; m_vh = '0;
    forever begin
      @(posedge clk);
`ifdef DTFAG_STALL_EN
      st = stall;
`else
      st = 1'b0;
`endif
      if (!rst_n) begin
        m_mode = 0; m_k = 0; m_d = 0; m_cen = 1'b1; m_vh = '0;
      end else begin
        m_vh = {m_vh[6:0], ~m_cen};
        case (m_mode)
          0: if (start) begin m_mode = 1; m_cen = 1'b0; end
          1: begin
            if (!m_cen) m_k++;
            if (m_k == TOTAL) begin m_mode = 2; m_cen = 1'b1; m_d = LAT; end
            else m_cen = st;
          end
          2: begin m_d--; if (m_d == 0) m_mode = 3; end
          default: begin m_mode = 0; m_k = 0; end
        endcase
      end
      #1;
      kk = m_k % TOTAL;
      exp = {m_mode == 1 || m_mode == 2, m_mode == 3, 2'(kk / 4096), 4'(kk / 256 % 16),
             4'(kk / 16 % 16), 4'(kk % 16), m_cen, m_vh[LAT-1]};
      chk("cycle", {busy, done, stage, DTFAG_i, DTFAG_t, DTFAG_j, ROM_CEN, tw_valid}, exp);
    end
  end
  initial begin
    int cyc, vcnt, dcyc, ndone, stall_left, stalled_once, seen1;
    logic [13:0] prev;
    rst_n = 1'b0; start = 1'b0; stall = 1'b0;
    stall_left = 0; stalled_once = 0; prev = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("idle_out", {ROM_CEN, busy, tw_valid, DTFAG_i, DTFAG_t, DTFAG_j}, {1'b1, 14'h0});
    // basic sweep with start pulses while busy (and the 7-cycle stall when enabled)
    start = 1'b1; cyc = 0; vcnt = 0; dcyc = -1; seen1 = 0;
    while (dcyc < 0 && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      start = (cyc == 5 || cyc == 3000);
      vcnt += int'(tw_valid);
      if (cyc == 1) chk("first_tuple", {stage, DTFAG_i, DTFAG_t, DTFAG_j, ROM_CEN}, 15'h0);
      if (cyc == 17) chk("cycle17", {stage, DTFAG_i, DTFAG_t, DTFAG_j}, 14'h0010);
`ifdef DTFAG_STALL_EN
      if (stall_left > 0) stall_left--;
      else if (stalled_once == 0 && {stage, DTFAG_i, DTFAG_t, DTFAG_j} == 14'h0008 && !ROM_CEN) begin
        stall_left = 7; stalled_once = 1;
      end
      stall = stall_left > 0;
      if (stalled_once == 1 && stall_left == 3)
        chk("stall_hold", {stage, DTFAG_i, DTFAG_t, DTFAG_j, ROM_CEN}, {14'h0009, 1'b1});
`endif
      if (stage == 2'd1 && seen1 == 0) begin
        seen1 = 1;
        chk("stage1_first", {stage, DTFAG_i, DTFAG_t, DTFAG_j}, 14'h1000);
        chk("stage0_last", prev, 14'h0fff);
        chk("stage1_cycle", cyc, 4097 + NST);
      end
      prev = {stage, DTFAG_i, DTFAG_t, DTFAG_j};
      if (done) dcyc = cyc;
    end
    start = 1'b0; stall = 1'b0;
    chk("done_cycle", dcyc, 16385 + LAT + NST);
    chk("valid_count", vcnt, TOTAL);
    ndone = 0;
    repeat (20) begin @(negedge clk); ndone += int'(done); end
    chk("single_done", ndone, 0);
    // reset in the middle of stage 2
    start = 1'b1;
    @(negedge clk);
    start = 1'b0; cyc = 1; ndone = 0;
    while (!({stage, DTFAG_i, DTFAG_t, DTFAG_j} == 14'h2345 && !ROM_CEN) && cyc < 12000) begin
      @(negedge clk);
      cyc++;
      ndone += int'(done);
    end
    chk("reach_mid", cyc, 9030);
    rst_n = 1'b0;
    #1;
    chk("async_reset", {busy, done, stage, DTFAG_i, DTFAG_t, DTFAG_j, ROM_CEN, tw_valid}, 18'h2);
    chk("no_done_mid", ndone, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    // fresh randomized run: start noise while busy, random stalls when enabled
    start = 1'b1; cyc = 0; vcnt = 0; dcyc = -1;
    while (dcyc < 0 && cyc < 40000) begin
      @(negedge clk);
      cyc++;
      start = $urandom_range(0, 31) == 0;
`ifdef DTFAG_STALL_EN
      stall = $urandom_range(0, 5) == 0;
`endif
      vcnt += int'(tw_valid);
      if (cyc == 1) chk("restart_first", {stage, DTFAG_i, DTFAG_t, DTFAG_j, ROM_CEN}, 15'h0);
      if (done) dcyc = cyc;
    end
    start = 1'b0; stall = 1'b0;
    chk("run3_done_seen", 32'(dcyc > 0), 1);
    chk("run3_valid_count", vcnt, TOTAL);
    repeat (5) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule

// File: doc/dtfag_seq_ctrl.md
# dtfag_seq_ctrl

Sequencer for the radix-16 DTFAG twiddle-factor address unit. On a start pulse it sweeps the AGU index triple (DTFAG_i, DTFAG_t, DTFAG_j) through every combination for each FFT stage. It drives the twiddle ROM chip-enable and emits a valid flag aligned with ROM read data. It sits between the FFT top-level controller and the DTFAG AGU/ROM pair.

## Interface
- RADIX_WIDTH, 4, width of each index counter; one index range = 2^RADIX_WIDTH values.
- NUM_STAGE, 4, number of FFT stages swept per start (65536-point, radix 16).
- ROM_LAT, 1, ROM read latency in cycles (1..4).
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle request; honoured only in IDLE.
- stall  input  1  present only with DTFAG_STALL_EN; freezes address generation.
- busy  output  1  high in RUN and DRAIN.
- done  output  1  one-cycle pulse in DONE.
- stage  output  clog2(NUM_STAGE)  current stage index.
- DTFAG_i  output  RADIX_WIDTH  outer index to AGU.
- DTFAG_t  output  RADIX_WIDTH  middle index to AGU.
- DTFAG_j  output  RADIX_WIDTH  inner index to AGU.
- ROM_CEN  output  1  ROM chip enable, active-low.
- tw_valid  output  1  high when ROM output data is valid; ROM_LAT cycles after the corresponding ROM_CEN=0.

## Operation
- Reset values:
  - state=IDLE; busy=0, done=0, stage=0.
  - DTFAG_i, DTFAG_t and DTFAG_j = 0.
  - ROM_CEN=1; tw_valid=0; valid pipeline cleared.
- States:
  - IDLE: start=1 -> RUN. Counters are already 0.
  - RUN: each non-stalled cycle issues one tuple with ROM_CEN=0.
  - Counter order: j increments every issue. j wraps 15->0 and increments t. t wraps and increments i. i wraps and increments stage.
  - RUN -> DRAIN on the cycle after tuple (i,t,j)=(15,15,15) of stage NUM_STAGE-1 is issued.
  - DRAIN: ROM_CEN=1. The state stays here for ROM_LAT cycles while the valid pipeline empties, then -> DONE.
  - DONE: done=1 for one cycle, all counters and stage return to 0, then -> IDLE.
- Tuples per stage: 2^(3·RADIX_WIDTH) = 4096. A full run issues NUM_STAGE·4096 = 16384 tuples, with no gaps absent stall.
- Valid pipeline: ROM_LAT-deep shift register. Its input is ~ROM_CEN and its output is tw_valid.
- start is ignored while busy=1 or done=1, with no queuing.
- Counters use modulo-2^RADIX_WIDTH arithmetic. stage wraps only through DONE and never exceeds NUM_STAGE-1.
- Reset asserted mid-run returns everything to reset values immediately. In-flight tw_valid is discarded.

## Timing
- All outputs are registered.
- First tuple: start sampled at edge N; at edge N+1 the state is RUN, outputs are (0,0,0), ROM_CEN=0, stage=0.
- tw_valid for a tuple issued with ROM_CEN=0 in cycle k is high in cycle k+ROM_LAT.
- Unstalled run length from start to done pulse: 1 + 16384 + ROM_LAT cycles. done is high in the last of these cycles.
- busy falls in the same cycle done rises.
- Stage boundary: tuple (15,15,15) of stage s is followed directly by (0,0,0) of stage s+1. There is no bubble.

## Configuration
- DTFAG_STALL_EN defined:
  - The stall port exists.
  - stall=1 in RUN holds all counters and stage, forces ROM_CEN=1, and shifts 0 into the valid pipeline.
  - The index triple on the outputs stays at the next unissued tuple.
  - stall in IDLE, DRAIN or DONE has no effect; DRAIN always completes.
- Not defined: no stall port; RUN issues one tuple every cycle unconditionally.

## Structure
- The shared FFT package holds:
  - the state typedef (IDLE, RUN, DRAIN, DONE);
  - RADIX_WIDTH and NUM_STAGE defaults, consistent with the existing radix_width define;
  - the localparam TUPLES_PER_STAGE.
- Sub-module dtfag_idx_cnt: a cascaded i/t/j counter with enable, clear, and a terminal-count output for stage increment. The state machine and valid pipeline stay in the top module.

## Test plan
- Reset then idle: rst_n low for 3 cycles, then 10 idle cycles -> ROM_CEN=1, busy=0, tw_valid=0, all indices 0 throughout.
- Basic sweep (ROM_LAT=1):
  - Stimulus: pulse start.
  - Next cycle: (0,0,0), ROM_CEN=0.
  - Cycle 17: (0,1,0).
  - Stage increments after 4096 issues.
  - done pulses exactly 16386 cycles after start.
  - Total tw_valid count = 16384.
- Ordering check: a scoreboard confirms issued tuples follow j-fastest, then t, then i order. The first stage-1 tuple is (0,0,0) with stage=1, immediately after (15,15,15) with stage=0.
- Start while busy: pulse start at cycles 5 and 3000 of a run -> no restart, tuple sequence unchanged, single done.
- Stall (DTFAG_STALL_EN, ROM_LAT=2):
  - Stimulus: stall high for 7 cycles at tuple (0,0,9).
  - Response: outputs hold (0,0,9) with ROM_CEN=1, tw_valid has a 7-cycle gap 2 cycles later, and done is delayed by exactly 7 cycles.
- Reset mid-run: assert rst_n low at tuple (3,4,5) of stage 2 -> outputs go to reset values asynchronously, no done pulse, and a new start sweeps again from stage 0.
